// File: rtl/ipq_pkg.sv
// Shared types and constants for instr_prefetch_queue and its ring buffer.
// The optional IPQ_BYPASS_EN feature is implemented in the top module.
package ipq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } ipqState_t;

  localparam int IPQ_INSTR_W = 16;
  localparam int IPQ_ADDR_W  = 16;

  // Default-width entry layout; ipq_ring re-declares it at its own parameter widths.
  typedef struct packed {
    logic [IPQ_INSTR_W-1:0] data;
    logic [IPQ_ADDR_W-1:0]  pc;
  } ipqEntry_t;

  localparam int NOP_INSTR = 0;

endpackage

// File: rtl/ipq_ring.sv
// Circular buffer of {instruction, pc} entries with push/pop and a single-cycle flush.
// Has no knowledge of the fetch protocol; the caller never pushes when full or pops when empty.
module ipq_ring #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [INSTR_W-1:0]       pushData,
  input  logic [ADDR_W-1:0]        pushPc,
  input  logic                     pop,
  output logic [INSTR_W-1:0]       headData,
  output logic [ADDR_W-1:0]        headPc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; only the pointers and count decide what is live.
  always_ff @(posedge clock) begin
    if (reset && !flush && push) mem[wrPtr] <= '{data: pushData, pc: pushPc};
  end

  assign headData = mem[rdPtr].data;
  assign headPc   = mem[rdPtr].pc;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch FSM and PC counter around an ipq_ring.
// Define IPQ_BYPASS_EN to forward a response straight to the decoder when the queue is empty.
module instr_prefetch_queue
  import ipq_pkg::*;
#(
  parameter int                INSTR_W  = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   fetch_req,
  output logic [ADDR_W-1:0]      fetch_addr,
  input  logic                   fetch_valid,
  input  logic [INSTR_W-1:0]     fetch_data,
  output logic [INSTR_W-1:0]     Instruction,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_addr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CAW = CW + 1;

  ipqState_t          state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  reqPc;
  logic [INSTR_W-1:0] headData;
  logic [ADDR_W-1:0]  headPc;
  logic               headValid;
  logic               pop;
  logic               push;
  logic               issue;
  logic [CAW-1:0]     countAfter;

  assign headValid = (count != '0);
  assign pop       = headValid && instr_ready && !redirect;

`ifdef IPQ_BYPASS_EN
  logic bypassTake;
  assign bypassTake = reset && !headValid && (state == WAIT) && fetch_valid
                      && !redirect && instr_ready;
  assign push       = reset && (state == WAIT) && fetch_valid && !redirect && !bypassTake;
`else
  assign push       = reset && (state == WAIT) && fetch_valid && !redirect;
`endif

  // A request is only issued if the slot it will fill is still free after this edge.
  assign countAfter = {1'b0, count} + CAW'(push) - CAW'(pop);
  assign issue      = reset && !redirect
                      && ((state == IDLE) || ((state == WAIT) && fetch_valid))
                      && (countAfter < CAW'(DEPTH));

  assign fetch_req  = issue;
  assign fetch_addr = pc;
  assign full       = (count == CW'(DEPTH));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      reqPc <= '0;
    end else if (redirect) begin
      pc    <= redirect_addr;
      state <= (((state == WAIT) || (state == DISCARD)) && !fetch_valid) ? DISCARD : IDLE;
    end else begin
      if (issue) begin
        pc    <= pc + 1'b1;
        reqPc <= pc;
      end
      case (state)
        IDLE:    if (issue) state <= WAIT;
        WAIT:    if (fetch_valid) state <= issue ? WAIT : IDLE;
        DISCARD: if (fetch_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    instr_valid = headValid;
    Instruction = headValid ? headData : INSTR_W'(NOP_INSTR);
    instr_pc    = headValid ? headPc : '0;
`ifdef IPQ_BYPASS_EN
    if (bypassTake) begin
      instr_valid = 1'b1;
      Instruction = fetch_data;
      instr_pc    = reqPc;
    end
`endif
  end

  ipq_ring #(
    .INSTR_W(INSTR_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) ring (
    .clock   (clock),
    .reset   (reset),
    .flush   (redirect),
    .push    (push),
    .pushData(fetch_data),
    .pushPc  (reqPc),
    .pop     (pop),
    .headData(headData),
    .headPc  (headPc),
    .count   (count)
  );

endmodule
